// File: rtl/branch_pkg.sv
// Shared types for the branch trace player: FSM state encoding and trace entry layout.
package branch_pkg;

    localparam int unsigned PC_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PHASE_A,
        PHASE_B,
        DONE
    } player_state_t;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0] pc;
        logic                    taken;
    } trace_entry_t;

endpackage

// File: rtl/trace_mem.sv
// Trace storage: register file with synchronous write and asynchronous read.
// Not cleared by reset so a stored trace survives a predictor-side reset.
module trace_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 11,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_trace_player.sv
// Replays a stored branch trace into a predictor, one entry per predict/resolve
// slot pair, and keeps saturating hit/miss counts of the returned predictions.
module branch_trace_player
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PC_W       = 10,
    parameter int unsigned CNT_W      = 16,
    parameter bit          SKIP_FIRST = 1'b1,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [PC_W-1:0]  load_pc,
    input  logic             load_taken,
    input  logic [AW:0]      trace_len,
    input  logic             start,
    output logic [PC_W-1:0]  PC,
    output logic             ActualBranch,
    input  logic             PredictedBranch,
    output logic             pred_reset,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    player_state_t    state_q, state_d;
    logic [AW-1:0]    idx_q;
    logic [AW:0]      len_q;
    logic [PC_W-1:0]  pc_q;
    logic             act_q;
    logic [CNT_W-1:0] hit_q, miss_q;

    logic             mem_we;
    logic [AW-1:0]    rd_addr;
    logic [PC_W:0]    rd_data;
    logic             last;
    logic             score;

    assign mem_we  = load_en && !busy && ({1'b0, load_addr} < DEPTH_V);
    // Read port addresses the entry the next PHASE_A will drive.
    assign rd_addr = (state_q == PHASE_B) ? idx_q + 1'b1 : '0;
    assign last    = ({1'b0, idx_q} == len_q - 1'b1);
    assign score   = (idx_q != '0) || !SKIP_FIRST;

    trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + 1)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata ({load_pc, load_taken}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        pred_reset = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                busy       = 1'b1;
                pred_reset = 1'b1;
                state_d    = (len_q == '0) ? DONE : PHASE_A;
            end
            PHASE_A: begin
                busy    = 1'b1;
                state_d = PHASE_B;
            end
            PHASE_B: begin
                busy    = 1'b1;
                state_d = last ? DONE : PHASE_A;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= '0;
            len_q  <= '0;
            pc_q   <= '0;
            act_q  <= '0;
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q  <= (trace_len > DEPTH_V) ? DEPTH_V : trace_len;
                        idx_q  <= '0;
                        hit_q  <= '0;
                        miss_q <= '0;
                    end
                end
                PHASE_B: begin
                    if (score) begin
                        if (PredictedBranch == act_q) begin
                            if (hit_q != '1) hit_q <= hit_q + 1'b1;
                        end else begin
                            if (miss_q != '1) miss_q <= miss_q + 1'b1;
                        end
                    end
                    if (!last) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
            // Outputs are loaded only when entering PHASE_A, so they hold through PHASE_B, DONE and IDLE.
            if (state_d == PHASE_A) begin
                pc_q  <= rd_data[PC_W:1];
                act_q <= rd_data[0];
            end
        end
    end

    assign PC           = pc_q;
    assign ActualBranch = act_q;
    assign hit_count    = hit_q;
    assign miss_count   = miss_q;

endmodule
